reg_file_32x32: RTL and testbench
=================================

Name: reg_file_32x32

Overview:
- Architectural register file for the single-cycle CPU.
- It is the consumer end of the 5-bit write-destination path. The 5-bit 2:1 destination select (rt vs rd) feeds WAddr, and this block decodes that address and commits WData on the clock edge.
- Provides two combinational read ports for rs/rt operand fetch and one synchronous write port.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W = 32.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns WData; 0 = returns the stored value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RAddr1  input  ADDR_W  read port 1 address (rs).
- RAddr2  input  ADDR_W  read port 2 address (rt).
- RData1  output  DATA_W  read port 1 data.
- RData2  output  DATA_W  read port 2 data.
- WE  input  1  write enable (RegWrite).
- WAddr  input  ADDR_W  write address, driven by the 5-bit destination select.
- WData  input  DATA_W  write data.
- WrCount  output  8  count of committed writes, for debug; wraps modulo 256.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Assertion takes effect immediately, regardless of clk.
- Reset values:
  - All 32 registers = 0.
  - WrCount = 0.
  - RData1/RData2 read 0 during reset, since they follow the cleared storage.
- Write:
  - On the rising edge of clk with rst_n=1, WE=1 and WAddr!=0: reg[WAddr] <= WData and WrCount <= WrCount+1.
  - Latency is one edge.
- Write to register 0:
  - WE=1 with WAddr=0 is discarded: reg[0] stays 0 and WrCount is not incremented.
  - reg[0] is never storage; the implementation may omit the flop.
- WE=0: no state change, whatever WAddr/WData hold. X on WAddr/WData while WE=0 must not corrupt state.
- Read:
  - Purely combinational, zero latency: RDataN = (RAddrN==0) ? 0 : reg[RAddrN].
  - Both ports are independent and may address the same register.
- Bypass, when BYPASS=1: if WE=1, WAddr!=0 and RAddrN==WAddr, then RDataN = WData in the same cycle. When BYPASS=0, RDataN shows the old value until the edge.
- Simultaneous events:
  - Read and write of the same register in one cycle: after the edge, reads return the new value.
  - Both read ports addressing the write address: both bypass identically.
- WrCount wrap: at 255, the next committed write gives 0. There is no saturation.
- Reset mid-operation:
  - If rst_n falls in the same cycle as WE=1, the write is lost and all state is 0.
  - First write is accepted on the first rising edge after rst_n rises, provided recovery timing is met.
- Width rules: no sign extension or truncation; WData is stored bit-exact.

Decomposition:
- Shared package/include `cpu_defs`:
  - REG_ZERO = 5'd0, plus named MIPS register constants (REG_RA = 5'd31, REG_SP = 5'd29).
  - DATA_W / ADDR_W defaults.
- One sub-module, `decoder_5_32`: combinational one-hot write-enable decode.
  - Function: en[i] = WE & (WAddr==i), with bit 0 forced low.
  - It is the demux counterpart of the destination select and is unit-tested separately.

Test Plan:
1. Reset: rst_n=0 with random WE/WAddr/WData toggling, then read all 32 addresses -> every RData = 0, WrCount = 0.
2. Write/read: write 0xDEADBEEF to reg 8, then 0x12345678 to reg 31; read with RAddr1=8, RAddr2=31 -> RData1=0xDEADBEEF, RData2=0x12345678, WrCount=2.
3. Zero register: WE=1, WAddr=0, WData=0xFFFFFFFF, one edge; read address 0 -> RData1 = 0, WrCount unchanged.
4. Bypass:
   - Reg 5 = 0x0000000A, then WE=1, WAddr=5, WData=0x0000000B, RAddr1=RAddr2=5.
   - Before the edge, BYPASS=1 -> both 0x0000000B; BYPASS=0 -> both 0x0000000A.
   - After the edge, both configurations -> 0x0000000B.
5. Async reset mid-write: write 0xCAFEF00D to reg 3, then assert rst_n=0 between edges -> RData for reg 3 is 0 immediately, before the next clk edge.
6. Counter wrap: 256 consecutive writes to reg 1 with incrementing data -> WrCount = 0 and reg 1 = data of the 256th write; WE=0 cycles inserted do not change WrCount.

Source files
------------

// File: rtl/reg_file_32x32_pkg.sv
// Shared CPU definitions: register-file geometry defaults and named MIPS
// register numbers used by the datapath.
package cpu_defs;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int WRCNT_W    = 8;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd29;
   localparam logic [4:0] REG_RA   = 5'd31;

   typedef logic [WRCNT_W-1:0] wr_count_t;
endpackage

// File: rtl/reg_file_32x32_decoder.sv
// One-hot write-enable decode for the register file; the demux counterpart of
// the destination-register select. Output bit 0 is permanently low.
module decoder_5_32
   import cpu_defs::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                     we_i,
   input  logic [ADDR_W-1:0]        addr_i,
   output logic [(2**ADDR_W)-1:0]   en_o
);
   localparam int DEPTH = 2 ** ADDR_W;

   assign en_o[0] = 1'b0;

   generate
      for (genvar gi = 1; gi < DEPTH; gi++) begin : g_dec
         // A low we_i masks any unknown address bits.
         assign en_o[gi] = we_i & (addr_i == ADDR_W'(gi));
      end
   endgenerate
endmodule

// File: rtl/reg_file_32x32.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, register 0 hardwired to zero, optional write-to-read bypass.
module reg_file_32x32
   import cpu_defs::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] RAddr1,
   input  logic [ADDR_W-1:0] RAddr2,
   output logic [DATA_W-1:0] RData1,
   output logic [DATA_W-1:0] RData2,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WAddr,
   input  logic [DATA_W-1:0] WData,
   output logic [7:0]        WrCount
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0]  wr_en;
   logic [DATA_W-1:0] regs_q [DEPTH];
   wr_count_t         wr_count_q;
   wr_count_t         wr_count_d;
   logic              commit;
   logic              byp_live;

   decoder_5_32 #(.ADDR_W(ADDR_W)) u_dec (
      .we_i   (WE),
      .addr_i (WAddr),
      .en_o   (wr_en)
   );

   // Entry 0 is never enabled, so it stays at its reset value of zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (wr_en[i]) regs_q[i] <= WData;
         end
      end
   end

   assign commit     = |wr_en;
   assign wr_count_d = commit ? wr_count_q + 8'd1 : wr_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_count_q <= '0;
      else        wr_count_q <= wr_count_d;
   end

   assign WrCount = wr_count_q;

   // Bypass is suppressed in reset so reads follow the cleared storage.
   assign byp_live = (BYPASS != 0) && rst_n && WE && (WAddr != '0);

   always_comb begin
      RData1 = (RAddr1 == '0) ? '0 : regs_q[RAddr1];
      RData2 = (RAddr2 == '0) ? '0 : regs_q[RAddr2];
      if (byp_live && (RAddr1 == WAddr)) RData1 = WData;
      if (byp_live && (RAddr2 == WAddr)) RData2 = WData;
   end
endmodule

// File: tb/tb_reg_file_32x32.sv
// Directed bench for reg_file_32x32: drives one bypassing and one
// non-bypassing instance with identical stimulus and checks both.
module tb_reg_file_32x32;
   logic        clk;
   logic        rst_n;
   logic [4:0]  RAddr1, RAddr2, WAddr;
   logic        WE;
   logic [31:0] WData;
   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic [7:0]  cnt_b, cnt_n;

   int errors = 0;
   int checks = 0;
   int exp_cnt;

   reg_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .RAddr1(RAddr1), .RAddr2(RAddr2),
      .RData1(rd1_b), .RData2(rd2_b), .WE(WE), .WAddr(WAddr),
      .WData(WData), .WrCount(cnt_b)
   );

   reg_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .RAddr1(RAddr1), .RAddr2(RAddr2),
      .RData1(rd1_n), .RData2(rd2_n), .WE(WE), .WAddr(WAddr),
      .WData(WData), .WrCount(cnt_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-24s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle_inputs();
      WE    = 1'b0;
      WAddr = 'x;
      WData = 'x;
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      WE = 1'b1; WAddr = a; WData = d;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic do_idle();
      @(negedge clk);
      idle_inputs();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; RAddr1 = '0; RAddr2 = '0;
      idle_inputs();

      // 1. Reset with random write activity, read all addresses
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         WE = 1'($urandom); WAddr = 5'($urandom); WData = $urandom;
         RAddr1 = 5'(i); RAddr2 = 5'(31 - i);
         #1;
         check($sformatf("rst_b_rd1[%0d]", i), rd1_b, 32'h0);
         check($sformatf("rst_n_rd2[%0d]", 31 - i), rd2_n, 32'h0);
      end
      check("rst_cnt_b", {24'h0, cnt_b}, 32'h0);
      check("rst_cnt_n", {24'h0, cnt_n}, 32'h0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;

      // 2. Basic write/read
      do_write(5'd8, 32'hDEADBEEF);
      do_write(5'd31, 32'h12345678);
      RAddr1 = 5'd8; RAddr2 = 5'd31; #1;
      check("wr_b_rd1", rd1_b, 32'hDEADBEEF);
      check("wr_b_rd2", rd2_b, 32'h12345678);
      check("wr_n_rd1", rd1_n, 32'hDEADBEEF);
      check("wr_n_rd2", rd2_n, 32'h12345678);
      check("wr_cnt", {24'h0, cnt_b}, 32'd2);

      // 3. Write to register 0 is discarded
      do_write(5'd0, 32'hFFFFFFFF);
      RAddr1 = 5'd0; #1;
      check("r0_b_rd1", rd1_b, 32'h0);
      check("r0_n_rd1", rd1_n, 32'h0);
      check("r0_cnt_b", {24'h0, cnt_b}, 32'd2);
      check("r0_cnt_n", {24'h0, cnt_n}, 32'd2);

      // 4. Bypass versus stored value
      do_write(5'd5, 32'h0000000A);
      @(negedge clk);
      WE = 1'b1; WAddr = 5'd5; WData = 32'h0000000B;
      RAddr1 = 5'd5; RAddr2 = 5'd5;
      #1;
      check("byp_pre_b_rd1", rd1_b, 32'h0000000B);
      check("byp_pre_b_rd2", rd2_b, 32'h0000000B);
      check("byp_pre_n_rd1", rd1_n, 32'h0000000A);
      check("byp_pre_n_rd2", rd2_n, 32'h0000000A);
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      check("byp_post_b_rd1", rd1_b, 32'h0000000B);
      check("byp_post_b_rd2", rd2_b, 32'h0000000B);
      check("byp_post_n_rd1", rd1_n, 32'h0000000B);
      check("byp_post_n_rd2", rd2_n, 32'h0000000B);
      check("byp_cnt", {24'h0, cnt_n}, 32'd4);

      // 5. Asynchronous reset between edges, with a write pending
      do_write(5'd3, 32'hCAFEF00D);
      RAddr1 = 5'd3; RAddr2 = 5'd8; #1;
      check("ar_pre_rd1", rd1_n, 32'hCAFEF00D);
      @(negedge clk);
      WE = 1'b1; WAddr = 5'd3; WData = 32'h11111111;
      #1 rst_n = 1'b0;
      #1;
      check("ar_b_rd1", rd1_b, 32'h0);
      check("ar_n_rd1", rd1_n, 32'h0);
      check("ar_b_rd2", rd2_b, 32'h0);
      check("ar_cnt", {24'h0, cnt_b}, 32'h0);
      @(posedge clk);
      #1;
      check("ar_edge_rd1", rd1_n, 32'h0);
      check("ar_edge_cnt", {24'h0, cnt_n}, 32'h0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      do_write(5'd7, 32'hA5A55A5A);
      RAddr1 = 5'd7; #1;
      check("ar_first_wr", rd1_b, 32'hA5A55A5A);
      check("ar_first_cnt", {24'h0, cnt_b}, 32'd1);

      // 6. Counter wrap from a clean reset, with idle cycles mixed in
      @(negedge clk);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      exp_cnt = 0;
      RAddr1 = 5'd1; RAddr2 = 5'd1;
      for (int i = 1; i <= 256; i++) begin
         do_write(5'd1, 32'(i));
         exp_cnt = (exp_cnt + 1) % 256;
         if (i % 64 == 0) begin
            do_idle();
            check($sformatf("wrap_idle_cnt[%0d]", i), {24'h0, cnt_n}, 32'(exp_cnt));
         end
         if (i == 255) check("wrap_cnt_255", {24'h0, cnt_b}, 32'd255);
      end
      #1;
      check("wrap_cnt_b", {24'h0, cnt_b}, 32'd0);
      check("wrap_cnt_n", {24'h0, cnt_n}, 32'd0);
      check("wrap_reg1_b", rd1_b, 32'h00000100);
      check("wrap_reg1_n", rd2_n, 32'h00000100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
